// File: rtl/transpose_buffer_if.sv
// transpose_buffer_if
//   Groups the sample-stream signals of the transpose buffer.
//   master : the producer/consumer around the buffer (testbench, datapath glue)
//   slave  : the transpose buffer itself
//   Signals:
//     in_data, in_valid      row-DCT result sample and its valid strobe
//     in_ready               a bank can accept the next sample
//     out_data               transposed sample
//     out_sum_diff_sel       0 = sum, 1 = difference in the downstream butterfly
//     out_load               out_data / out_sum_diff_sel valid
//     overflow               sticky: a sample arrived while in_ready was low
interface transpose_buffer_if #(
  parameter int DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sum_diff_sel;
  logic                  out_load;
  logic                  overflow;

  modport master (
    output in_data, in_valid,
    input  in_ready, out_data, out_sum_diff_sel, out_load, overflow
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_data, out_sum_diff_sel, out_load, overflow
  );
endinterface

// File: rtl/transpose_buffer.sv
// transpose_buffer
//   Ping-pong N x N transpose memory between the row and column DCT passes.
//   Samples are written row-major into one bank while the other bank is read
//   column-major, with rows inside each column paired outside-in
//   (0, N-1, 1, N-2, ...) so the downstream butterfly gets sum/diff pairs.
//   Ports:
//     clk   single clock, rising edge
//     rst   synchronous, active-high reset
//     bus   transpose_buffer_if.slave (input stream, output stream, overflow)
module transpose_buffer #(
  parameter int DATA_WIDTH = 10,
  parameter int N          = 8
) (
  input  logic                clk,
  input  logic                rst,
  transpose_buffer_if.slave   bus
);
  localparam int L  = $clog2(N);
  localparam int AW = 2 * L;
  localparam logic [L-1:0] ROW_MAX = L'(N - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_t;
  typedef enum logic {IDLE, READ} rd_state_t;

  bank_t                 bank_st [2];
  logic                  wptr;
  logic                  rptr;
  logic [L-1:0]          wr_r;
  logic [L-1:0]          wr_c;
  rd_state_t             rd_state;
  logic [AW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] mem [2*N*N];

  logic                  in_ready;
  logic                  wr_fire;
  logic                  rd_start;
  logic                  rd_en;
  logic                  rd_last;
  logic [L-1:0]          rd_col;
  logic [L-1:0]          rd_row;
  logic [AW:0]           rd_addr;
  logic [AW:0]           wr_addr;

  logic [DATA_WIDTH-1:0] out_data_p1;
  logic                  sel_p1;
  logic                  vld_p1;
  logic                  overflow_q;

  // Position k inside a column maps outside-in onto rows: even k walks down
  // from row 0, odd k walks up from row N-1.
  function automatic logic [L-1:0] pair_row(input logic [L-1:0] k);
    logic [L-1:0] half;
    half = k >> 1;
    return k[0] ? (ROW_MAX - half) : half;
  endfunction

  assign in_ready = (bank_st[wptr] == EMPTY) || (bank_st[wptr] == FILLING);
  assign wr_fire  = bus.in_valid && in_ready;
  assign wr_addr  = {wptr, wr_r, wr_c};

  // The first address of a block goes out in the same cycle the FULL bank is
  // seen, which gives the two-cycle accept-to-load latency and lets a
  // following block start without a bubble.
  assign rd_start = (rd_state == IDLE) && (bank_st[rptr] == FULL);
  assign rd_en    = rd_start || (rd_state == READ);
  assign rd_last  = rd_en && (rd_idx == '1);
  assign rd_col   = rd_idx[AW-1:L];
  assign rd_row   = pair_row(rd_idx[L-1:0]);
  assign rd_addr  = {rptr, rd_row, rd_col};

  // Sample memory, no reset: stale contents are never read because a bank is
  // only drained after a full block has been written into it.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr] <= bus.in_data;
  end

  // ---- stage p0 -> p1: bank bookkeeping, address issue, registered read ----
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0]  <= EMPTY;
      bank_st[1]  <= EMPTY;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      wr_r        <= '0;
      wr_c        <= '0;
      rd_state    <= IDLE;
      rd_idx      <= '0;
      overflow_q  <= 1'b0;
      out_data_p1 <= '0;
      sel_p1      <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      // Write side only touches a bank that is EMPTY/FILLING and the read
      // side only one that is FULL/DRAINING, so the updates never collide.
      if (wr_fire) begin
        wr_c <= wr_c + 1'b1;
        if (wr_c == ROW_MAX) wr_r <= wr_r + 1'b1;
        if ((wr_c == ROW_MAX) && (wr_r == ROW_MAX)) begin
          bank_st[wptr] <= FULL;
          wptr          <= ~wptr;
        end else begin
          bank_st[wptr] <= FILLING;
        end
      end
      if (bus.in_valid && !in_ready) overflow_q <= 1'b1;

      if (rd_en) rd_idx <= rd_idx + 1'b1;
      if (rd_start) begin
        bank_st[rptr] <= DRAINING;
        rd_state      <= READ;
      end
      if (rd_last) begin
        bank_st[rptr] <= EMPTY;
        rptr          <= ~rptr;
        if (bank_st[~rptr] == FULL) begin
          bank_st[~rptr] <= DRAINING;
          rd_state       <= READ;
        end else begin
          rd_state       <= IDLE;
        end
      end

      vld_p1      <= rd_en;
      sel_p1      <= rd_en && rd_idx[0];
      out_data_p1 <= rd_en ? mem[rd_addr] : '0;
    end
  end

  assign bus.in_ready         = in_ready;
  assign bus.out_data         = out_data_p1;
  assign bus.out_sum_diff_sel = sel_p1;
  assign bus.out_load         = vld_p1;
  assign bus.overflow         = overflow_q;
endmodule
